// File: rtl/acceso_pkg.sv
// Shared definitions for the barrier arbiter and the PIN access controller:
// barrier phase encodings, lane identifiers and default timing.
package acceso_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ABRIENDO = 2'd1,
    ABIERTA  = 2'd2,
    CERRANDO = 2'd3
  } estado_t;

  localparam logic LANE_ENTRADA = 1'b0;
  localparam logic LANE_SALIDA  = 1'b1;

  // Default travel/pass windows, shared with the PIN controller.
  localparam int T_MOV_DEF  = 50;
  localparam int T_PASO_DEF = 200;

endpackage

// File: rtl/arbitro_compuerta_if.sv
// Lane request / barrier motor bundle between the access side (master)
// and the barrier arbiter (slave).
interface arbitro_compuerta_if #(
  parameter int CNT_W = 8
);

  logic             req_entrada;
  logic             req_salida;
  logic             sensor_paso;
  logic             gnt_entrada;
  logic             gnt_salida;
  logic             motor_abrir;
  logic             motor_cerrar;
  logic             lleno;
  logic [CNT_W-1:0] ocupacion;
  logic             alarma_timeout;

  modport master (
    output req_entrada, req_salida, sensor_paso,
    input  gnt_entrada, gnt_salida, motor_abrir, motor_cerrar,
    input  lleno, ocupacion, alarma_timeout
  );

  modport slave (
    input  req_entrada, req_salida, sensor_paso,
    output gnt_entrada, gnt_salida, motor_abrir, motor_cerrar,
    output lleno, ocupacion, alarma_timeout
  );

endinterface

// File: rtl/arbitro_compuerta_temporizador.sv
// Loadable down-counter used for both the barrier travel window and the
// wait-for-pass window; cero is high while the count sits at zero.
module temporizador_compuerta #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carga,
  input  logic [W-1:0] valor,
  output logic         cero
);

  logic [W-1:0] cuenta_q;
  logic [W-1:0] cuenta_d;

  // Next count: load wins, otherwise count down and park at zero.
  always_comb begin
    cuenta_d = cuenta_q;
    if (carga) begin
      cuenta_d = valor;
    end else if (cuenta_q != '0) begin
      cuenta_d = cuenta_q - W'(1);
    end else begin
      cuenta_d = cuenta_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign cero = (cuenta_q == '0);

endmodule

// File: rtl/arbitro_compuerta.sv
// Barrier arbiter: round-robin between entry and exit lanes, motor sequencing
// and occupancy count. Optional macro SAFETY_REVERSE_EN reopens on an obstacle.
module arbitro_compuerta
  import acceso_pkg::*;
#(
  parameter int CAPACIDAD = 16,
  parameter int T_MOV     = T_MOV_DEF,
  parameter int T_PASO    = T_PASO_DEF,
  parameter int CNT_W     = 8
) (
  input logic               clock,
  input logic               reset,
  arbitro_compuerta_if.slave bus
);

  localparam int T_MAX = (T_MOV > T_PASO) ? T_MOV : T_PASO;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0]    T_MOV_M1  = TW'(T_MOV - 1);
  localparam logic [TW-1:0]    T_PASO_M1 = TW'(T_PASO - 1);
  localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACIDAD);

  estado_t          estado_q, estado_d;
  logic             lane_q, lane_d;
  logic             ultimo_q, ultimo_d;
  logic [CNT_W-1:0] ocup_q, ocup_d;
  logic             alarma_q, alarma_d;
  logic             sensor_q, sensor_d;
  logic             carga_s;
  logic [TW-1:0]    valor_s;
  logic             cero_s;
  logic             flanco_s;
  logic             elig_e_s;
  logic             elig_s_s;
  logic [CNT_W-1:0] contada_s;
`ifdef SAFETY_REVERSE_EN
  logic             contado_q, contado_d;
`endif

  function automatic logic [CNT_W-1:0] contar(input logic [CNT_W-1:0] o, input logic lane);
    if (lane == LANE_ENTRADA) begin
      contar = (o == CAP_V) ? o : o + CNT_W'(1);
    end else begin
      contar = (o == '0) ? o : o - CNT_W'(1);
    end
  endfunction

  temporizador_compuerta #(.W(TW)) u_temp (
    .clock (clock),
    .reset (reset),
    .carga (carga_s),
    .valor (valor_s),
    .cero  (cero_s)
  );

  assign flanco_s  = bus.sensor_paso && !sensor_q;
  assign elig_e_s  = bus.req_entrada && (ocup_q != CAP_V);
  assign elig_s_s  = bus.req_salida;
  assign contada_s = contar(ocup_q, lane_q);

  // Phase sequencing, lane arbitration and occupancy update.
  always_comb begin
    estado_d = estado_q;
    lane_d   = lane_q;
    ultimo_d = ultimo_q;
    ocup_d   = ocup_q;
    alarma_d = 1'b0;
    sensor_d = bus.sensor_paso;
    carga_s  = 1'b0;
    valor_s  = T_MOV_M1;
`ifdef SAFETY_REVERSE_EN
    contado_d = contado_q;
`endif
    case (estado_q)
      IDLE: begin
        if (elig_e_s || elig_s_s) begin
          // The round-robin pointer only moves when both lanes contend.
          if (elig_e_s && elig_s_s) begin
            lane_d   = ~ultimo_q;
            ultimo_d = ~ultimo_q;
          end else begin
            lane_d = elig_s_s ? LANE_SALIDA : LANE_ENTRADA;
          end
          estado_d = ABRIENDO;
          carga_s  = 1'b1;
`ifdef SAFETY_REVERSE_EN
          contado_d = 1'b0;
`endif
        end else begin
          estado_d = IDLE;
        end
      end
      ABRIENDO: begin
        if (cero_s) begin
          estado_d = ABIERTA;
          carga_s  = 1'b1;
          valor_s  = T_PASO_M1;
        end else begin
          estado_d = ABRIENDO;
        end
      end
      ABIERTA: begin
        if (flanco_s) begin
`ifdef SAFETY_REVERSE_EN
          ocup_d    = contado_q ? ocup_q : contada_s;
          contado_d = 1'b1;
`else
          ocup_d = contada_s;
`endif
          estado_d = CERRANDO;
          carga_s  = 1'b1;
        end else if (cero_s) begin
          alarma_d = 1'b1;
          estado_d = CERRANDO;
          carga_s  = 1'b1;
        end else begin
          estado_d = ABIERTA;
        end
      end
      CERRANDO: begin
`ifdef SAFETY_REVERSE_EN
        if (bus.sensor_paso) begin
          estado_d = ABRIENDO;
          carga_s  = 1'b1;
        end else if (cero_s) begin
          estado_d = IDLE;
        end else begin
          estado_d = CERRANDO;
        end
`else
        if (cero_s) begin
          estado_d = IDLE;
        end else begin
          estado_d = CERRANDO;
        end
`endif
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  // State, lane, pointer, occupancy and alarm registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= IDLE;
      lane_q   <= LANE_ENTRADA;
      ultimo_q <= LANE_SALIDA;
      ocup_q   <= '0;
      alarma_q <= 1'b0;
      sensor_q <= 1'b0;
`ifdef SAFETY_REVERSE_EN
      contado_q <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      lane_q   <= lane_d;
      ultimo_q <= ultimo_d;
      ocup_q   <= ocup_d;
      alarma_q <= alarma_d;
      sensor_q <= sensor_d;
`ifdef SAFETY_REVERSE_EN
      contado_q <= contado_d;
`endif
    end
  end

  assign bus.gnt_entrada    = (estado_q != IDLE) && (lane_q == LANE_ENTRADA);
  assign bus.gnt_salida     = (estado_q != IDLE) && (lane_q == LANE_SALIDA);
  assign bus.motor_abrir    = (estado_q == ABRIENDO);
  assign bus.motor_cerrar   = (estado_q == CERRANDO);
  assign bus.lleno          = (ocup_q == CAP_V);
  assign bus.ocupacion      = ocup_q;
  assign bus.alarma_timeout = alarma_q;

endmodule

// File: doc/arbitro_compuerta.md
Name: arbitro_compuerta

Overview:
- Shares one motorised barrier between an entry lane (fed by the PIN access controller's grant) and an exit lane (exit push-button or loop).
- Sequences the barrier motor through open, wait-for-pass, and close phases using cycle timers.
- Keeps the parking occupancy count and blocks entry when the lot is full.
- Sits between the access/PIN controller and the barrier motor driver.

Parameters:
- CAPACIDAD, 16: number of parking spaces; entry is refused when occupancy equals this value.
- T_MOV, 50: barrier travel time in clock cycles, for opening or closing; must be at least 1.
- T_PASO, 200: maximum cycles the barrier stays open waiting for a vehicle to pass; must be at least 1.
- CNT_W, 8: width of the occupancy counter; must satisfy 2^CNT_W > CAPACIDAD.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- req_entrada  in  1  level request from the entry lane (PIN accepted)
- req_salida  in  1  level request from the exit lane
- sensor_paso  in  1  vehicle-under-barrier loop; high while a vehicle occupies the loop
- gnt_entrada  out  1  entry lane is being served
- gnt_salida  out  1  exit lane is being served
- motor_abrir  out  1  drive barrier open
- motor_cerrar  out  1  drive barrier closed
- lleno  out  1  occupancy equals CAPACIDAD
- ocupacion  out  CNT_W  current vehicles inside
- alarma_timeout  out  1  one-cycle pulse when no vehicle passed within T_PASO

Behaviour:
- Interface: reset is synchronous and active-high; clock is clock. All state changes on the rising edge of clock.
- Reset (including mid-operation):
  - State goes to IDLE; all outputs go to 0; ocupacion goes to 0.
  - The round-robin pointer is set to favour entry; the timer is cleared; the edge-detect register for sensor_paso is cleared.
- States: IDLE, ABRIENDO, ABIERTA, CERRANDO.
- IDLE:
  - Eligible requests are req_entrada && !lleno, and req_salida.
  - If exactly one is eligible, grant it. If both are eligible, grant the lane not served last (round-robin), then update the pointer.
  - The grant registers on the same edge as the transition to ABRIENDO. The timer loads T_MOV-1.
- Grants:
  - gnt_* is one-hot and held from entry into ABRIENDO until the return to IDLE.
  - Requests are sampled only in IDLE. A request that drops during service has no effect on the service in progress.
- ABRIENDO: motor_abrir=1. When the timer reaches 0, go to ABIERTA and load T_PASO-1. Open latency from request to motor_abrir is 1 cycle.
- ABIERTA: both motor outputs are 0.
  - Rising edge of sensor_paso (registered edge detect):
    - If entry is granted, ocupacion increments.
    - If exit is granted, ocupacion decrements, saturating at 0.
    - Go to CERRANDO and load T_MOV-1.
  - Timer reaches 0 with no edge: alarma_timeout=1 for one cycle, ocupacion is unchanged, go to CERRANDO.
  - If the edge and the timeout occur in the same cycle, the pass wins: count updates and no alarm.
- CERRANDO: motor_cerrar=1. When the timer reaches 0, go to IDLE and drop the grant. A new grant is possible on the next edge (the cycle after IDLE is entered).
- Occupancy:
  - Entry never increments past CAPACIDAD, because requests are blocked while lleno.
  - lleno = (ocupacion == CAPACIDAD), combinational from the register.
- motor_abrir and motor_cerrar are never both 1.

Optional Feature:
- Macro: SAFETY_REVERSE_EN.
- Defined: sensor_paso high (level) in CERRANDO forces a transition to ABRIENDO with the timer reloaded to T_MOV-1. The grant and lane are kept, and the count is not updated again. After reopening, the block returns to ABIERTA with a fresh T_PASO window. A later pass edge in that window does not update the count again; a per-service "counted" flag enforces this.
- Not defined: sensor_paso is ignored in CERRANDO.

Decomposition:
- Shared package acceso_pkg holds:
  - state encodings (IDLE, ABRIENDO, ABIERTA, CERRANDO);
  - lane ID constants LANE_ENTRADA=0, LANE_SALIDA=1;
  - a default timing constant shared with the PIN controller.
- One natural sub-module: temporizador_compuerta, a loadable down-counter with load value, load strobe and zero flag. It is reused for both the T_MOV and T_PASO windows.

Test Plan:
- Entry pulse, then sensor_paso rising 10 cycles into ABIERTA (T_MOV=4, T_PASO=20) -> gnt_entrada one cycle after the request; motor_abrir for 4 cycles; ocupacion 0→1; motor_cerrar for 4 cycles; back to IDLE.
- req_entrada and req_salida held together from reset with ocupacion=1 -> entry served first, then exit; ocupacion 1→2→1; grants never overlap.
- ocupacion=CAPACIDAD (16), lleno=1, only req_entrada held -> no grant and motors stay idle. Then an exit with pass -> ocupacion 15, lleno=0, and the pending entry is granted next.
- Entry with no sensor_paso for T_PASO=20 cycles -> alarma_timeout high exactly 1 cycle; ocupacion unchanged; barrier closes.
- reset asserted during ABIERTA with ocupacion=3 -> next cycle all outputs 0 and ocupacion 0.
- With SAFETY_REVERSE_EN, sensor_paso high at cycle 2 of CERRANDO -> ABRIENDO (motor_abrir), then ABIERTA, and ocupacion is incremented only once. Without the macro, closing completes.
